// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 timing defaults, the timing-decode bundle
//               carried through the read-latency delay line, and a total helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 22;
    localparam int c_H_SYNC   = 93;
    localparam int c_H_BP     = 45;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 11;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 32;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
    } vga_tim_t;

    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Generic DEPTH-stage register delay for any type T; DEPTH=0 is
//               a plain wire. Synchronous active-low clear empties every stage.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int  DEPTH = 1,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  T     i_data,
    output T     o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n};
            assign o_data   = i_data;
        end else begin : g_pipe
            T r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen_param.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_param
// Description : Parametrised VGA timing generator: h/v counters, sync/enable/
//               strobe decode aligned to a 0..3 cycle framebuffer read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen_param
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = c_H_ACTIVE,
    parameter int   H_FP        = c_H_FP,
    parameter int   H_SYNC      = c_H_SYNC,
    parameter int   H_BP        = c_H_BP,
    parameter int   V_ACTIVE    = c_V_ACTIVE,
    parameter int   V_FP        = c_V_FP,
    parameter int   V_SYNC      = c_V_SYNC,
    parameter int   V_BP        = c_V_BP,
    parameter logic HSYNC_POL   = 1'b0,
    parameter logic VSYNC_POL   = 1'b0,
    parameter int   RD_LATENCY  = 0,
    parameter int   SCALE_SHIFT = 3,
    parameter int   COORD_W     = 10
) (
    input  logic                           CLK_25MHz,
    input  logic                           RST_N,
    input  logic [2:0]                     RED,
    input  logic [2:0]                     GREEN,
    input  logic [1:0]                     BLUE,
    output logic [COORD_W-1:0]             ROW,
    output logic [COORD_W-1:0]             COLUMN,
    output logic [COORD_W-SCALE_SHIFT-1:0] FB_ROW,
    output logic [COORD_W-SCALE_SHIFT-1:0] FB_COL,
    output logic [2:0]                     ROUT,
    output logic [2:0]                     GOUT,
    output logic [1:0]                     BOUT,
    output logic                           HSYNC,
    output logic                           VSYNC,
    output logic                           ACTIVE,
    output logic                           FRAME_START,
    output logic                           LINE_START
);

    localparam int c_H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (c_H_TOTAL > (2 ** COORD_W)) begin : g_err_h_total
            $error("vga_timing_gen_param: H_TOTAL does not fit in COORD_W bits");
        end
        if (c_V_TOTAL > (2 ** COORD_W)) begin : g_err_v_total
            $error("vga_timing_gen_param: V_TOTAL does not fit in COORD_W bits");
        end
        if ((RD_LATENCY < 0) || (RD_LATENCY > 3)) begin : g_err_latency
            $error("vga_timing_gen_param: RD_LATENCY must be 0..3");
        end
    endgenerate

    // Decode compares run one bit wider so a region end equal to 2**COORD_W stays exact.
    localparam logic [COORD_W-1:0] c_H_LAST    = COORD_W'(c_H_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_V_LAST    = COORD_W'(c_V_TOTAL - 1);
    localparam logic [COORD_W:0]   c_H_ACT_END = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0]   c_V_ACT_END = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W:0]   c_HS_BEG    = (COORD_W+1)'(H_ACTIVE + H_FP);
    localparam logic [COORD_W:0]   c_HS_END    = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W:0]   c_VS_BEG    = (COORD_W+1)'(V_ACTIVE + V_FP);
    localparam logic [COORD_W:0]   c_VS_END    = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] r_h, r_v, w_h_d, w_v_d;
    logic [COORD_W:0]   w_h_x, w_v_x;
    logic               w_h_wrap, w_v_wrap;
    vga_tim_t           w_tim_raw, w_tim_dly;

    logic [2:0] r_red, r_green, w_red_d, w_green_d;
    logic [1:0] r_blue, w_blue_d;
    logic       r_hsync, r_vsync, r_act, r_fs, r_ls;
    logic       w_hsync_d, w_vsync_d;

    assign w_h_x = {1'b0, r_h};
    assign w_v_x = {1'b0, r_v};

    always_comb begin
        w_h_wrap = (r_h == c_H_LAST);
        w_v_wrap = (r_v == c_V_LAST);
        w_h_d    = w_h_wrap ? '0 : r_h + COORD_W'(1);
        w_v_d    = r_v;
        if (w_h_wrap) begin
            w_v_d = w_v_wrap ? '0 : r_v + COORD_W'(1);
        end
    end

    always_comb begin
        w_tim_raw     = '0;
        w_tim_raw.act = (w_h_x < c_H_ACT_END) && (w_v_x < c_V_ACT_END);
        w_tim_raw.hs  = (w_h_x >= c_HS_BEG) && (w_h_x < c_HS_END);
        w_tim_raw.vs  = (w_v_x >= c_VS_BEG) && (w_v_x < c_VS_END);
        w_tim_raw.fs  = (r_h == '0) && (r_v == '0);
        w_tim_raw.ls  = (r_h == '0) && (w_v_x < c_V_ACT_END);
    end

    // Timing bits wait out the framebuffer read so they meet their pixel's RGB.
    vga_delay_line #(
        .DEPTH (RD_LATENCY),
        .T     (vga_tim_t)
    ) u_tim_dly (
        .clk    (CLK_25MHz),
        .rst_n  (RST_N),
        .i_data (w_tim_raw),
        .o_data (w_tim_dly)
    );

    always_comb begin
        w_red_d   = w_tim_dly.act ? RED   : 3'd0;
        w_green_d = w_tim_dly.act ? GREEN : 3'd0;
        w_blue_d  = w_tim_dly.act ? BLUE  : 2'd0;
        w_hsync_d = w_tim_dly.hs ? HSYNC_POL : ~HSYNC_POL;
        w_vsync_d = w_tim_dly.vs ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge CLK_25MHz) begin
        if (!RST_N) begin
            r_h     <= '0;
            r_v     <= '0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_act   <= 1'b0;
            r_fs    <= 1'b0;
            r_ls    <= 1'b0;
        end else begin
            r_h     <= w_h_d;
            r_v     <= w_v_d;
            r_red   <= w_red_d;
            r_green <= w_green_d;
            r_blue  <= w_blue_d;
            r_hsync <= w_hsync_d;
            r_vsync <= w_vsync_d;
            r_act   <= w_tim_dly.act;
            r_fs    <= w_tim_dly.fs;
            r_ls    <= w_tim_dly.ls;
        end
    end

    assign ROW         = r_v;
    assign COLUMN      = r_h;
    assign FB_ROW      = r_v[COORD_W-1:SCALE_SHIFT];
    assign FB_COL      = r_h[COORD_W-1:SCALE_SHIFT];
    assign ROUT        = r_red;
    assign GOUT        = r_green;
    assign BOUT        = r_blue;
    assign HSYNC       = r_hsync;
    assign VSYNC       = r_vsync;
    assign ACTIVE      = r_act;
    assign FRAME_START = r_fs;
    assign LINE_START  = r_ls;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen_param.md
Name: vga_timing_gen_param

Overview:
- Parametrised successor to the fixed 640x480 VGA driver, for the OTTER MCU on Basys3.
- Generates horizontal/vertical counters, sync pulses with programmable polarity, a display-enable signal, and frame/line start strobes.
- Presents full-resolution and down-scaled framebuffer coordinates, and aligns RGB, sync and enable for a framebuffer read latency of 0..3 cycles.
- Sits between the framebuffer RAM (addressed by FB_ROW/FB_COL) and the VGA connector pins.

Parameters:
- H_ACTIVE, 640, visible columns
- H_FP, 22, horizontal front porch (pixels)
- H_SYNC, 93, horizontal sync width (pixels)
- H_BP, 45, horizontal back porch (pixels)
- V_ACTIVE, 480, visible rows
- V_FP, 11, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 32, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of HSYNC (0 = active-low)
- VSYNC_POL, 0, asserted level of VSYNC
- RD_LATENCY, 0, framebuffer read latency in cycles (0..3)
- SCALE_SHIFT, 3, log2 of the down-scale factor for FB coordinates (3 gives 80x60)
- COORD_W, 10, coordinate counter width

Ports:
- CLK_25MHz  in  1  pixel clock
- RST_N  in  1  synchronous active-low reset
- RED  in  3  framebuffer red data
- GREEN  in  3  framebuffer green data
- BLUE  in  2  framebuffer blue data
- ROW  out  COORD_W  vertical counter (coordinate presented to memory)
- COLUMN  out  COORD_W  horizontal counter
- FB_ROW  out  COORD_W-SCALE_SHIFT  ROW >> SCALE_SHIFT
- FB_COL  out  COORD_W-SCALE_SHIFT  COLUMN >> SCALE_SHIFT
- ROUT  out  3  red output
- GOUT  out  3  green output
- BOUT  out  2  blue output
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- ACTIVE  out  1  display enable, aligned with RGB
- FRAME_START  out  1  one-cycle strobe, aligned with output pixel (0,0)
- LINE_START  out  1  one-cycle strobe, aligned with output column 0 of each visible row

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Elaboration error if H_TOTAL > 2**COORD_W, V_TOTAL > 2**COORD_W, or RD_LATENCY > 3.
- Counters:
  - h increments every cycle, wraps H_TOTAL-1 -> 0.
  - v increments only on h wrap, wraps V_TOTAL-1 -> 0.
  - Frame period = H_TOTAL*V_TOTAL cycles (420000 by default).
- ROW/COLUMN/FB_ROW/FB_COL are combinational from the counters, with no register. They describe the pixel whose RGB must be present on RED/GREEN/BLUE RD_LATENCY cycles later.
- Raw timing decode (combinational on h, v):
  - act = h<H_ACTIVE && v<V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
  - fs = (h==0 && v==0)
  - ls = (h==0 && v<V_ACTIVE)
- Alignment:
  - The {act, hs, vs, fs, ls} decode passes through a RD_LATENCY-stage delay line, then a final output register. Total latency from counter value to pins = RD_LATENCY+1 cycles.
  - In the final register, RGB are captured from the inputs when the delayed act=1, and forced to 0 otherwise.
  - RD_LATENCY=0 reproduces legacy timing: the pixel output one cycle after the coordinate is presented.
- Sync polarity:
  - HSYNC = delayed hs ? HSYNC_POL : ~HSYNC_POL; VSYNC likewise with VSYNC_POL.
- Reset, when RST_N=0 on a clock edge:
  - h = v = 0.
  - All delay-line stages cleared to act=hs=vs=fs=ls=0.
  - ROUT/GOUT/BOUT = 0; ACTIVE, FRAME_START, LINE_START = 0; HSYNC = ~HSYNC_POL; VSYNC = ~VSYNC_POL.
  - Reset applied mid-frame behaves identically. No stale pipeline data may reach the pins after release.
- After release: on the first edge with RST_N=1, h goes 0 -> 1. FRAME_START asserts on the (RD_LATENCY+1)th edge after release, together with ACTIVE=1 and RGB of pixel (0,0).
- Boundaries:
  - h wrap and v wrap occur on the same edge at (H_TOTAL-1, V_TOTAL-1).
  - FRAME_START and LINE_START are both high for pixel (0,0).
  - No strobes occur during vertical blanking lines.

Decomposition:
- Package vga_pkg:
  - localparam defaults for 640x480@60 timing.
  - Typedef vga_tim_t, a packed struct {act, hs, vs, fs, ls} carried through the delay line.
  - Function vga_total() for computing totals.
- Sub-module vga_delay_line: generic, parameterised over DEPTH (0 = passthrough) and type T, with synchronous active-low clear. Instantiated once for vga_tim_t.

Test Plan:
- Defaults, RD_LATENCY=0, after reset:
  - HSYNC low for exactly 93 cycles per line, starting 663 edges after the line's COLUMN=0 presentation.
  - Line period 800 cycles; VSYNC low for exactly 2 lines (1600 cycles) per frame.
  - Frame period 420000 cycles.
- RD_LATENCY=2, bench memory model returning RGB=f(ROW,COLUMN) after 2 cycles: every cycle with ACTIVE=1 outputs f of the correct coordinate; ACTIVE high 640 cycles per line on 480 lines; RGB=0 whenever ACTIVE=0.
- HSYNC_POL=1, VSYNC_POL=1: sync pulses high with the same widths; both syncs idle low at reset.
- FB coordinates: at COLUMN=639, ROW=479, FB_COL=79 and FB_ROW=59; FB_COL steps once every 8 pixels.
- Reset mid-frame at ROW=300, COLUMN=100 with RD_LATENCY=3: during reset and the 3 cycles after, all outputs hold reset values. FRAME_START arrives exactly 4 edges after release.
- Small-timing parameter set (H 8/1/2/1, V 4/1/1/1, SCALE_SHIFT 1): exact cycle-by-cycle match to the reference model over 3 frames, including FRAME_START and LINE_START coincident at (0,0).
